// File: rtl/slice_scanner_pkg.sv
// Shared display definitions for the slice scanner: blank levels, FSM states,
// and the address-width helper used for every counter and address bus.
package slice_scanner_pkg;

  localparam logic BLANK_ROW_BIT = 1'b1;
  localparam logic BLANK_COL_BIT = 1'b0;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // clog2 with a floor of 1 so single-entry dimensions still get a legal bus
  function automatic int addr_w(input int n);
    int w;
    w = 1;
    for (int k = 1; k < 32; k++)
      if ((1 << k) < n) w = k + 1;
    return w;
  endfunction

endpackage

// File: rtl/slice_scanner_frame_ram.sv
// Frame buffer: one write port, one registered read port, read-before-write.
// No reset on the array or read register so it maps onto block RAM.
module frame_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 16,
  parameter int AW    = 7
) (
  input  logic             i_clock,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_q <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/slice_scanner.sv
// Persistence-of-vision row scanner: on each revolution marker, sweeps every
// slice/row of the frame buffer with a blank guard cycle at the start of each row slot.
module slice_scanner
  import slice_scanner_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int SLICES = 8,
  parameter int DWELL  = 4,
  localparam int SW    = addr_w(SLICES),
  localparam int RW    = addr_w(ROWS)
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic            cycle_marker,
  input  logic            wr_en,
  input  logic [SW-1:0]   wr_slice,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  output logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [SW-1:0]   slice_idx,
  output logic            scanning,
  output logic            resync
);

  localparam int DEPTH = SLICES * ROWS;
  localparam int AW    = addr_w(DEPTH);
  localparam int DW    = addr_w(DWELL);

  localparam logic [DW-1:0] DW_LAST = DW'(DWELL - 1);
  localparam logic [RW-1:0] RW_LAST = RW'(ROWS - 1);
  localparam logic [SW-1:0] SW_LAST = SW'(SLICES - 1);
  localparam logic [ROWS-1:0] ROW_BLANK = {ROWS{BLANK_ROW_BIT}};
  localparam logic [COLS-1:0] COL_BLANK = {COLS{BLANK_COL_BIT}};

  scan_state_e r_state, w_state_nx;
  logic [DW-1:0] r_dwell, w_dwell_nx;
  logic [RW-1:0] r_rowc, w_rowc_nx;
  logic [SW-1:0] r_slicec, w_slicec_nx;
  logic          w_resync_nx;

  logic r_mark, r_armed;
  logic w_edge, w_last, w_drive;

  logic [ROWS-1:0] r_row;
  logic [SW-1:0]   r_slice_o;
  logic            r_show, r_scan, r_resync;

  logic [AW-1:0]   w_raddr, w_waddr;
  logic [COLS-1:0] w_rdata;
  logic            w_wr_ok;

  // r_armed blocks a marker that was already high across reset release
  assign w_edge = cycle_marker & ~r_mark & r_armed;
  assign w_last = (r_dwell == DW_LAST) && (r_rowc == RW_LAST) && (r_slicec == SW_LAST);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state  <= ST_WAIT;
      r_dwell  <= '0;
      r_rowc   <= '0;
      r_slicec <= '0;
      r_mark   <= 1'b0;
      r_armed  <= ~cycle_marker;
    end else begin
      r_state  <= w_state_nx;
      r_dwell  <= w_dwell_nx;
      r_rowc   <= w_rowc_nx;
      r_slicec <= w_slicec_nx;
      r_mark   <= cycle_marker;
      if (!cycle_marker) r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_dwell_nx  = r_dwell;
    w_rowc_nx   = r_rowc;
    w_slicec_nx = r_slicec;
    w_resync_nx = 1'b0;
    case (r_state)
      ST_WAIT: begin
        w_dwell_nx  = '0;
        w_rowc_nx   = '0;
        w_slicec_nx = '0;
        if (w_edge) w_state_nx = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_edge || w_last) begin
          w_dwell_nx  = '0;
          w_rowc_nx   = '0;
          w_slicec_nx = '0;
          w_resync_nx = w_edge;
          if (!w_edge) w_state_nx = ST_WAIT;
        end else if (r_dwell != DW_LAST) begin
          w_dwell_nx = r_dwell + 1'b1;
        end else begin
          w_dwell_nx = '0;
          if (r_rowc != RW_LAST) begin
            w_rowc_nx = r_rowc + 1'b1;
          end else begin
            w_rowc_nx   = '0;
            w_slicec_nx = r_slicec + 1'b1;
          end
        end
      end
      default: w_state_nx = ST_WAIT;
    endcase
  end

  // dwell 0 of every row slot is the blank guard cycle
  assign w_drive = (r_state == ST_SCAN) && (r_dwell != '0);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_row     <= ROW_BLANK;
      r_show    <= 1'b0;
      r_slice_o <= '0;
      r_scan    <= 1'b0;
      r_resync  <= 1'b0;
    end else begin
      r_row     <= w_drive ? ~(ROWS'(1) << r_rowc) : ROW_BLANK;
      r_show    <= w_drive;
      r_slice_o <= r_slicec;
      r_scan    <= (r_state == ST_SCAN);
      r_resync  <= w_resync_nx;
    end
  end

  assign w_raddr = AW'(32'(r_slicec) * ROWS + 32'(r_rowc));
  assign w_waddr = AW'(32'(wr_slice) * ROWS + 32'(wr_row));
  assign w_wr_ok = wr_en && rst_n && (32'(wr_slice) < SLICES) && (32'(wr_row) < ROWS);

  frame_ram #(
    .DEPTH (DEPTH),
    .WIDTH (COLS),
    .AW    (AW)
  ) u_ram (
    .i_clock   (clock),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (w_waddr),
    .i_wr_data (wr_data),
    .i_rd_addr (w_raddr),
    .o_rd_data (w_rdata)
  );

  // RAM read register lines up with the output registers, so col just gates it
  assign col       = r_show ? w_rdata : COL_BLANK;
  assign row       = r_row;
  assign slice_idx = r_slice_o;
  assign scanning  = r_scan;
  assign resync    = r_resync;

endmodule

// File: tb/tb_slice_scanner.sv
// Directed-sequence bench with random frame data, checked every cycle against
// a scan-position model (output after edge p reflects scan index p - start - 1).
module tb_slice_scanner;

  localparam int ROWS = 16, COLS = 16, SLICES = 8, DWELL = 4;
  localparam int SCAN_LEN = SLICES * ROWS * DWELL;

  logic            clock = 1'b0;
  logic            rst_n = 1'b0;
  logic            cycle_marker = 1'b0;
  logic            wr_en = 1'b0;
  logic [2:0]      wr_slice = '0;
  logic [3:0]      wr_row = '0;
  logic [COLS-1:0] wr_data = '0;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic [2:0]      slice_idx;
  logic            scanning, resync;

  slice_scanner #(.ROWS(ROWS), .COLS(COLS), .SLICES(SLICES), .DWELL(DWELL)) dut (
    .clock(clock), .rst_n(rst_n), .cycle_marker(cycle_marker),
    .wr_en(wr_en), .wr_slice(wr_slice), .wr_row(wr_row), .wr_data(wr_data),
    .row(row), .col(col), .slice_idx(slice_idx), .scanning(scanning), .resync(resync)
  );

  always #5 clock = ~clock;

  int vecs = 0, errs = 0;
  int cyc = 0, t0 = 0;
  bit sv = 0, prev_mk = 0, seen_low = 0;
  int scan_hi = 0, resync_cnt = 0;
  logic [COLS-1:0] mem [SLICES*ROWS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    logic rs, mk, we, edge_d;
    int wa, i, r, eslice;
    logic [COLS-1:0] wd, ecol;
    logic [ROWS-1:0] erow;
    logic escan, eres;
    rs = rst_n; mk = cycle_marker; we = wr_en; wd = wr_data;
    wa = int'(wr_slice) * ROWS + int'(wr_row);
    @(posedge clock);
    cyc++;
    #1;
    erow = '1; ecol = '0; eslice = 0; escan = 1'b0; eres = 1'b0; edge_d = 1'b0;
    if (rs) begin
      edge_d = mk && !prev_mk && seen_low;
      i = cyc - t0 - 1;
      if (sv && i < SCAN_LEN) begin
        escan  = 1'b1;
        eslice = i / (ROWS * DWELL);
        r      = (i / DWELL) % ROWS;
        if (i % DWELL != 0) begin
          erow = ~(16'd1 << r);
          ecol = mem[eslice * ROWS + r];
        end
      end
      eres = edge_d && escan;
    end
    chk("row", 32'(row), 32'(erow));
    chk("col", 32'(col), 32'(ecol));
    chk("slice_idx", 32'(slice_idx), 32'(eslice));
    chk("scanning", 32'(scanning), 32'(escan));
    chk("resync", 32'(resync), 32'(eres));
    if (scanning === 1'b1) scan_hi++;
    if (resync === 1'b1) resync_cnt++;
    if (!rs) begin
      sv = 1'b0; seen_low = !mk; prev_mk = mk;
    end else begin
      prev_mk = mk;
      if (!mk) seen_low = 1'b1;
      if (edge_d) begin t0 = cyc; sv = 1'b1; end
      if (we) mem[wa] = wd;
    end
  endtask

  task automatic rand_write();
    wr_en    = 1'b1;
    wr_slice = 3'($urandom_range(2, SLICES - 1));
    wr_row   = 4'($urandom_range(0, ROWS - 1));
    wr_data  = 16'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // fill frame buffer; (0,0) and (1,2) carry known words
    for (int a = 0; a < SLICES * ROWS; a++) begin
      wr_en    = 1'b1;
      wr_slice = 3'(a / ROWS);
      wr_row   = 4'(a % ROWS);
      wr_data  = (a == 0) ? 16'h0FF0 : (a == 18) ? 16'h5555 : 16'($urandom);
      tick();
    end
    wr_en = 1'b0;
    repeat (5) tick();

    // single full scan with a same-cycle write to the word being read
    scan_hi = 0;
    cycle_marker = 1'b1;
    for (int k = 0; k < 540; k++) begin
      if (k == 3) cycle_marker = 1'b0;
      wr_en = 1'b0;
      if (k > 0 && cyc + 1 - t0 == 74) begin
        wr_en = 1'b1; wr_slice = 3'd1; wr_row = 4'd2; wr_data = 16'hAAAA;
      end else if (k > 4 && $urandom_range(0, 9) == 0) begin
        rand_write();
      end
      tick();
      if (k > 0 && cyc - t0 == 2) begin
        chk("first_row", 32'(row), 32'h0000FFFE);
        chk("first_col", 32'(col), 32'h00000FF0);
      end
      if (k > 0 && cyc - t0 == 74) chk("same_cyc_old", 32'(col), 32'h00005555);
      if (k > 0 && cyc - t0 == 75) chk("same_cyc_new", 32'(col), 32'h0000AAAA);
    end
    wr_en = 1'b0;
    chk("scan_len", 32'(scan_hi), 32'(SCAN_LEN));

    // restart 100 cycles into a scan
    resync_cnt = 0;
    cycle_marker = 1'b1;
    for (int k = 0; k < 150; k++) begin
      if (k == 3) cycle_marker = 1'b0;
      if (k == 100) cycle_marker = 1'b1;
      wr_en = 1'b0;
      if ($urandom_range(0, 7) == 0) rand_write();
      tick();
    end
    wr_en = 1'b0;
    chk("resync_cnt", 32'(resync_cnt), 32'd1);

    // one-cycle reset mid-scan, marker held high, write attempt ignored
    rst_n = 1'b0;
    wr_en = 1'b1; wr_slice = 3'd7; wr_row = 4'd15; wr_data = 16'hDEAD;
    tick();
    rst_n = 1'b1;
    wr_en = 1'b0;
    scan_hi = 0;
    repeat (30) tick();
    chk("no_restart", 32'(scan_hi), 32'd0);

    // fresh edge after the marker falls; full scan shows (7,15) untouched
    cycle_marker = 1'b0;
    repeat (2) tick();
    cycle_marker = 1'b1;
    scan_hi = 0;
    repeat (540) tick();
    chk("scan_len2", 32'(scan_hi), 32'(SCAN_LEN));
    cycle_marker = 1'b0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
